// File: rtl/serial_addsub_nbit.sv
// Bit-serial LSB-first two's-complement adder/subtractor built around one full-adder slice.
// start/done handshake; result, carry-out and signed-overflow flag are registered at completion.
module serial_addsub_nbit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             c_msb_in;

   logic accept;
   logic sum_bit;
   logic carry_nxt;
   logic last_bit;

   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   // The single full-adder slice shared by every bit position
   assign sum_bit   = fa_sum(a_sr[0], b_sr[0], carry);
   assign carry_nxt = fa_carry(a_sr[0], b_sr[0], carry);
   assign last_bit  = (cnt == CNT_LAST);

   // Requests arriving while a computation is running are dropped, not queued
   assign accept = start && (state != SHIFT);

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            if (start) state_nxt = SHIFT;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: invert B on load and seed the carry with mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         acc      <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= mode ? ~b : b;
         acc   <= '0;
         cnt   <= '0;
         carry <= mode;
      end else if (state == SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         acc   <= {sum_bit, acc[WIDTH-1:1]};
         carry <= carry_nxt;
         cnt   <= cnt + 1'b1;
         if (cnt == CNT_PEN) begin
            c_msb_in <= carry_nxt;
         end
      end
   end

   // Outputs update only on the final bit, so they stay stable through SHIFT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if ((state == SHIFT) && last_bit) begin
         result <= {sum_bit, acc[WIDTH-1:1]};
         cout   <= carry_nxt;
         ovf    <= c_msb_in ^ carry_nxt;
      end
   end

endmodule
